// File: rtl/fp_leading_one_scan.sv
// Segmented leading/trailing-one finder.
// Captures a LEN-bit operand on a valid/ready handshake and scans it SEG bits per cycle
// in search order, stopping at the first non-zero segment. The index is returned on a
// second valid/ready handshake.
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   valid_i      operand valid
//   ready_o      block can accept an operand
//   in_i         operand
//   mode_i       0 = leading one (count from MSB), 1 = trailing one (count from LSB)
//   valid_o      result valid
//   ready_i      consumer accepts result
//   first_one_o  result index
//   no_ones_o    operand was all zero
module fp_leading_one_scan #(
    parameter int unsigned LEN  = 64,
    parameter int unsigned SEG  = 16,
    parameter int unsigned NSEG = LEN / SEG,
    parameter int unsigned IdxW = $clog2(LEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [LEN-1:0]  in_i,
    input  logic            mode_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [IdxW-1:0] first_one_o,
    output logic            no_ones_o
);

    localparam int unsigned KW   = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int unsigned SegW = (SEG > 1) ? $clog2(SEG) : 1;
    // Truncates to zero when SEG==LEN, which is harmless because k is then always 0.
    localparam logic [IdxW-1:0] SegStep = IdxW'(SEG);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q;
    logic [LEN-1:0]    op_q;
    logic              mode_q;
    logic [IdxW-1:0]   first_one_q;
    logic              no_ones_q;

    logic [SEG-1:0]    seg;
    logic [SegW-1:0]   j;
    logic              hit;
    logic              last_seg;
    logic [IdxW-1:0]   idx;

    // Select segment k in search order: MSB-first for mode 0, LSB-first for mode 1.
    always_comb begin
        seg = '0;
        for (int i = 0; i < int'(NSEG); i++) begin
            if (k_q == KW'(i)) begin
                seg = mode_q ? op_q[i*SEG +: SEG] : op_q[LEN-1-i*SEG -: SEG];
            end
        end
    end

    // Local finder. Later loop iterations override earlier ones, so iteration order
    // picks the highest bit (mode 0, j from top) or the lowest bit (mode 1, j from bottom).
    always_comb begin
        j = '0;
        if (mode_q) begin
            for (int i = int'(SEG) - 1; i >= 0; i--) begin
                if (seg[i]) j = SegW'(i);
            end
        end else begin
            for (int i = 0; i < int'(SEG); i++) begin
                if (seg[i]) j = SegW'(int'(SEG) - 1 - i);
            end
        end
    end

    assign hit      = |seg;
    assign last_seg = (k_q == KW'(NSEG - 1));
    assign idx      = IdxW'(k_q) * SegStep + IdxW'(j);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (valid_i) state_d = StScan;
            StScan: if (hit || last_seg) state_d = StDone;
            StDone: if (ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        ready_o = (state_q == StIdle) & ~rst_i;
        valid_o = (state_q == StDone);
    end

    assign first_one_o = first_one_q;
    assign no_ones_o   = no_ones_q;

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            k_q         <= '0;
            op_q        <= '0;
            mode_q      <= 1'b0;
            first_one_q <= '0;
            no_ones_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid_i) begin
                        op_q   <= in_i;
                        mode_q <= mode_i;
                        k_q    <= '0;
                    end
                end
                StScan: begin
                    if (hit) begin
                        first_one_q <= idx;
                        no_ones_q   <= 1'b0;
                    end else if (last_seg) begin
                        first_one_q <= '0;
                        no_ones_q   <= 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_leading_one_scan.sv
module tb_fp_leading_one_scan;

    localparam int LEN  = 64;
    localparam int SEG  = 16;
    localparam int IdxW = 6;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            valid_i;
    logic            ready_o;
    logic [LEN-1:0]  in_i;
    logic            mode_i;
    logic            valid_o;
    logic            ready_i;
    logic [IdxW-1:0] first_one_o;
    logic            no_ones_o;

    int checks = 0;
    int errors = 0;

    fp_leading_one_scan #(.LEN(LEN), .SEG(SEG)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .in_i       (in_i),
        .mode_i     (mode_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .first_one_o(first_one_o),
        .no_ones_o  (no_ones_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LEN-1:0] in;
        logic           mode;
        logic [IdxW-1:0] idx;
        logic           none;
        int             lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the handshake edge.
    task automatic run_op(input vec_t v);
        int lat;
        lat = 0;
        chk("ready_before_accept", 64'(ready_o), 64'd1);
        valid_i = 1'b1;
        in_i    = v.in;
        mode_i  = v.mode;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        in_i    = ~v.in;
        mode_i  = ~v.mode;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (valid_o) begin
                lat = c;
                break;
            end
        end
        chk("latency", 64'(lat), 64'(v.lat));
        chk("first_one", 64'(first_one_o), 64'(v.idx));
        chk("no_ones", 64'(no_ones_o), 64'(v.none));
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        chk("valid_after_hs", 64'(valid_o), 64'd0);
        chk("ready_after_hs", 64'(ready_o), 64'd1);
        chk("idx_retained", 64'(first_one_o), 64'(v.idx));
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{64'h8000_0000_0000_0000, 1'b0, 6'd0,  1'b0, 1};
        vecs[1]  = '{64'h0000_0000_0000_0001, 1'b0, 6'd63, 1'b0, 4};
        vecs[2]  = '{64'h0000_0F00_0000_0001, 1'b0, 6'd20, 1'b0, 2};
        vecs[3]  = '{64'h0000_0F00_0000_0001, 1'b1, 6'd0,  1'b0, 1};
        vecs[4]  = '{64'h0000_0000_0010_0000, 1'b1, 6'd20, 1'b0, 2};
        vecs[5]  = '{64'h8000_0000_0000_0000, 1'b1, 6'd63, 1'b0, 4};
        vecs[6]  = '{64'h0000_0000_0000_0000, 1'b0, 6'd0,  1'b1, 4};
        vecs[7]  = '{64'h0000_0000_0000_0000, 1'b1, 6'd0,  1'b1, 4};
        vecs[8]  = '{64'h0001_0000_0000_0000, 1'b0, 6'd15, 1'b0, 1};
        vecs[9]  = '{64'h0000_0000_0000_8000, 1'b1, 6'd15, 1'b0, 1};
        vecs[10] = '{64'h0000_8000_0000_0000, 1'b0, 6'd16, 1'b0, 2};
        vecs[11] = '{64'h0000_0000_0003_0000, 1'b1, 6'd16, 1'b0, 2};

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; in_i = '0; mode_i = 1'b0;
        #1;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_idx", 64'(first_one_o), 64'd0);
        chk("rst_none", 64'(no_ones_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        chk("ready_after_rst", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) run_op(vecs[i]);

        // Reset mid-scan: operand needs 4 cycles, abort after the first scan cycle.
        chk("pre_rst_idx", 64'(first_one_o), 64'd16);
        valid_i = 1'b1; in_i = 64'h1; mode_i = 1'b0;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        #1;
        chk("abort_valid", 64'(valid_o), 64'd0);
        chk("abort_idx", 64'(first_one_o), 64'd0);
        chk("abort_none", 64'(no_ones_o), 64'd0);
        chk("abort_ready", 64'(ready_o), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        chk("abort_ready_release", 64'(ready_o), 64'd1);
        begin
            logic stale;
            stale = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1;
                if (valid_o) stale = 1'b1;
            end
            chk("no_stale_result", 64'(stale), 64'd0);
        end

        // Backpressure: bit 8 in mode 1 gives index 8 after one cycle.
        valid_i = 1'b1; in_i = 64'h100; mode_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_valid_rise", 64'(valid_o), 64'd1);
        for (int c = 0; c < 5; c++) begin
            valid_i = c[0] ? 1'b0 : 1'b1;
            in_i    = {$urandom, $urandom} | 64'h1;
            mode_i  = c[0];
            @(posedge clk);
            #1;
            chk("bp_valid", 64'(valid_o), 64'd1);
            chk("bp_idx", 64'(first_one_o), 64'd8);
            chk("bp_none", 64'(no_ones_o), 64'd0);
            chk("bp_ready", 64'(ready_o), 64'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        chk("bp_hs_valid", 64'(valid_o), 64'd0);
        chk("bp_hs_ready", 64'(ready_o), 64'd1);
        v = '{64'h0000_0000_0000_0001, 1'b0, 6'd63, 1'b0, 4};
        run_op(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
